regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
// - Debug read-side initiator for regfile. On start, walks every architectural register in
//   ascending order, reading two at a time through the regfile rs1/rs2 read ports.
// - Streams each value out on a valid/ready port, with 2-entry output buffering.
// - Sits beside decode; a debug mux hands it the read ports while busy=1.
// - The core must hold rd_wren low while busy=1, so the dump is a consistent snapshot.
// PARAMETERS
// - NUM_REGS  32  registers to dump; must be even and >= 2
// - ADDR_W     5  register address width; 2**ADDR_W >= NUM_REGS
// - DATA_W    32  register data width
// PORTS
// - clk           in   1       clock, rising edge
// - rst_n         in   1       asynchronous active-low reset
// - start         in   1       pulse: begin a dump; ignored while busy=1
// - rs1_addr      out  ADDR_W  to regfile read port 1 (even register of the pair)
// - rs2_addr      out  ADDR_W  to regfile read port 2 (odd register of the pair)
// - rs1_data      in   DATA_W  from regfile, combinational read of rs1_addr
// - rs2_data      in   DATA_W  from regfile, combinational read of rs2_addr
// - busy          out  1       dump in progress; read ports owned by this block
// - dump_valid    out  1       output beat available
// - dump_ready    in   1       sink accepts beat; a handshake is valid&ready at a rising edge
// - dump_data     out  DATA_W  register value (or checksum)
// - dump_idx      out  ADDR_W  register index of the beat; 0 on the checksum beat
// - dump_last     out  1       final beat of the dump
// - dump_is_csum  out  1       beat is the checksum word; tied 0 without the macro
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; pair counter 0; FIFO empty.
//   All outputs are 0: busy, dump_valid, dump_data, dump_idx, dump_last, dump_is_csum,
//   rs1_addr, rs2_addr.
// - FSM states: IDLE, READ, DRAIN, CSUM (CSUM exists only with the macro).
//   - IDLE: start=1 at an edge -> READ, pair counter p=0, busy=1.
//   - READ: rs1_addr={p,0}, rs2_addr={p,1}, driven from the registered counter.
//     - Capture condition: FIFO count==0, or count==1 and a pop occurs the same edge.
//     - On capture: push (rs1_data, idx 2p) then (rs2_data, idx 2p+1), p++.
//     - When the capture of pair NUM_REGS/2-1 completes -> DRAIN.
//   - DRAIN: addresses held at 0; wait for FIFO empty.
//     - Without the macro: empty -> IDLE, busy=0.
//     - With the macro: empty -> CSUM.
//   - IDLE and DRAIN drive rs1_addr=rs2_addr=0.
// - FIFO: 2 entries, strict order. dump_* outputs come from the head entry.
//   - Head data, idx and flags are stable while dump_valid=1 and dump_ready=0.
//   - dump_valid=1 iff count>0 (or in the CSUM state).
// - dump_last=1 only on the final beat: idx NUM_REGS-1, or the checksum beat with the macro.
// - Timing with dump_ready held 1 and start at edge 0:
//   - busy=1 after edge 0; first capture at edge 1; dump_valid=1 after edge 1.
//   - One beat per cycle, no bubbles; beats handshake at edges 2..NUM_REGS+1.
//   - busy=0 after the last handshake (edge NUM_REGS+1; +1 edge with the macro).
// - start while busy is ignored: no restart and no counter disturbance.
// - start in the same cycle the dump ends (busy still 1) is also ignored.
// - Backpressure: while the FIFO is full, no capture occurs and the addresses hold their value.
// - Mid-dump reset: immediate return to reset values; the partial dump is discarded.
//   The next start restarts at index 0.
// CONFIGURATION
// - DUMP_CHECKSUM_EN defined:
//   - A running XOR accumulator, cleared on start, XORs each pushed word.
//   - After DRAIN, the CSUM state presents a beat: dump_data=XOR of all NUM_REGS words,
//     dump_idx=0, dump_is_csum=1, dump_last=1, dump_valid=1.
//   - That beat is held until handshake -> IDLE, busy=0.
// - DUMP_CHECKSUM_EN undefined:
//   - No accumulator and no CSUM state; dump_is_csum is tied to 0.
//   - dump_last is asserted on idx NUM_REGS-1.
// TESTING
// - Full dump: preload x[i]=32'h1000_0000+i (x0 reads 0), ready=1, start pulse.
//   -> 32 beats, idx 0..31, data matches, last only on idx 31, busy falls after edge 33.
// - Backpressure: ready random 50%.
//   -> Exactly 32 beats in order, no loss or duplicates.
//   -> dump_data and dump_idx stable whenever valid=1 and ready=0.
// - Busy start: start pulses at beats 5 and 31.
//   -> Single 32-beat dump; the counter is undisturbed.
// - Mid-dump reset: assert rst_n=0 after beat idx 10.
//   -> All outputs 0 at once; a new start yields a dump beginning at idx 0.
// - Checksum (DUMP_CHECKSUM_EN): x[i]=i*32'h0101_0101.
//   -> 33rd beat has dump_is_csum=1, last=1, data=XOR of all values (XOR i=0..31 of i = 0),
//      i.e. 32'h0000_0000.
//   -> Repeat with x[5]=32'hDEAD_BEEF -> checksum = 32'hDEAD_BEEF^32'h0505_0505.
// - Read-port check: monitor rs1_addr/rs2_addr.
//   -> Pairs (0,1),(2,3)..(30,31) each appear before their beats; addresses are 0 when idle.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Debug read-side initiator: streams every architectural register out of the regfile, two per read.
// Optional feature macro: DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump_reader #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rs1_addr,
   output logic [ADDR_W-1:0] rs2_addr,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   output logic              busy,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [ADDR_W-1:0] dump_idx,
   output logic              dump_last,
   output logic              dump_is_csum
);

   localparam int unsigned PAIR_W = ADDR_W - 1;
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
`ifdef DUMP_CHECKSUM_EN
      , S_CSUM = 2'd3
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [PAIR_W-1:0] pair_q;
   logic [1:0]        count_q;
   logic [DATA_W-1:0] head_data_q, tail_data_q;
   logic [ADDR_W-1:0] head_idx_q, tail_idx_q;
   logic              head_last_q, tail_last_q;
   logic              start_c, pop_c, capture_c, drained_c;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
   logic              head_csum_q;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and datapath strobes; a capture refills both FIFO slots at once
   always_comb begin
      state_d   = state_q;
      start_c   = 1'b0;
      capture_c = 1'b0;
      pop_c     = (count_q != 2'd0) && dump_ready;
      drained_c = (count_q == 2'd0) || ((count_q == 2'd1) && pop_c);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_c = 1'b1;
               state_d = S_READ;
            end
         end
         S_READ: begin
            capture_c = (count_q == 2'd0) || ((count_q == 2'd1) && pop_c);
            if (capture_c && (pair_q == LAST_PAIR)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
`ifdef DUMP_CHECKSUM_EN
            if (drained_c) state_d = S_CSUM;
`else
            if (drained_c) state_d = S_IDLE;
`endif
         end
`ifdef DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (dump_ready) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Pair counter and 2-entry output FIFO (head/tail shift pair)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_q      <= '0;
         count_q     <= 2'd0;
         head_data_q <= '0;
         tail_data_q <= '0;
         head_idx_q  <= '0;
         tail_idx_q  <= '0;
         head_last_q <= 1'b0;
         tail_last_q <= 1'b0;
      end else begin
         if (start_c) pair_q <= '0;
         if (capture_c) begin
            head_data_q <= rs1_data;
            tail_data_q <= rs2_data;
            head_idx_q  <= {pair_q, 1'b0};
            tail_idx_q  <= {pair_q, 1'b1};
            head_last_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            tail_last_q <= 1'b0;
`else
            tail_last_q <= (pair_q == LAST_PAIR);
`endif
            count_q     <= 2'd2;
            pair_q      <= pair_q + PAIR_W'(1);
         end else if (pop_c) begin
            head_data_q <= tail_data_q;
            head_idx_q  <= tail_idx_q;
            head_last_q <= tail_last_q;
            count_q     <= count_q - 2'd1;
         end
`ifdef DUMP_CHECKSUM_EN
         // The checksum beat is loaded into the head slot, overriding any same-edge shift
         if ((state_q == S_DRAIN) && (state_d == S_CSUM)) begin
            head_data_q <= csum_q;
            head_idx_q  <= '0;
            head_last_q <= 1'b1;
         end else if ((state_q == S_CSUM) && dump_ready) begin
            head_last_q <= 1'b0;
         end
`endif
      end
   end

`ifdef DUMP_CHECKSUM_EN
   // Running XOR of every pushed word, plus the head checksum flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q      <= '0;
         head_csum_q <= 1'b0;
      end else begin
         if (start_c)        csum_q <= '0;
         else if (capture_c) csum_q <= csum_q ^ rs1_data ^ rs2_data;
         if ((state_q == S_DRAIN) && (state_d == S_CSUM))  head_csum_q <= 1'b1;
         else if ((state_q == S_CSUM) && dump_ready)       head_csum_q <= 1'b0;
      end
   end

   assign dump_valid   = (count_q != 2'd0) || (state_q == S_CSUM);
   assign dump_is_csum = head_csum_q;
`else
   assign dump_valid   = (count_q != 2'd0);
   assign dump_is_csum = 1'b0;
`endif

   assign busy      = (state_q != S_IDLE);
   assign rs1_addr  = (state_q == S_READ) ? {pair_q, 1'b0} : '0;
   assign rs2_addr  = (state_q == S_READ) ? {pair_q, 1'b1} : '0;
   assign dump_data = head_data_q;
   assign dump_idx  = head_idx_q;
   assign dump_last = head_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: randomized register contents and sink backpressure.
module tb_regfile_dump_reader;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;
`ifdef DUMP_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   localparam int BEATS = NUM_REGS + int'(CSUM_EN);

   logic              clk, rst_n, start;
   logic [ADDR_W-1:0] rs1_addr, rs2_addr;
   logic [DATA_W-1:0] rs1_data, rs2_data;
   logic              busy, dump_valid, dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic [ADDR_W-1:0] dump_idx;
   logic              dump_last, dump_is_csum;

   logic [DATA_W-1:0] rf [NUM_REGS];

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] idx;
      logic              last;
      logic              csum;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    beats_done = 0;
   int    seen_pair = -1;
   bit    rand_ready = 1'b0;

   regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .busy(busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_data(dump_data), .dump_idx(dump_idx),
      .dump_last(dump_last), .dump_is_csum(dump_is_csum)
   );

   // Regfile model: combinational reads, x0 hardwired to zero
   assign rs1_data = (rs1_addr == '0) ? '0 : rf[rs1_addr];
   assign rs2_data = (rs2_addr == '0) ? '0 : rf[rs2_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Expected dump: every register in index order, then the XOR of all of them if enabled
   task automatic push_dump();
      logic [DATA_W-1:0] acc;
      beat_t             b;
      acc = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         b.data = (i == 0) ? '0 : rf[i];
         b.idx  = ADDR_W'(i);
         b.last = !CSUM_EN && (i == NUM_REGS - 1);
         b.csum = 1'b0;
         acc ^= b.data;
         exp_q.push_back(b);
      end
      if (CSUM_EN) begin
         b.data = acc;
         b.idx  = '0;
         b.last = 1'b1;
         b.csum = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   task automatic start_dump();
      push_dump();
      beats_done = 0;
      seen_pair  = -1;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         cyc();
         if (!busy) done = 1'b1;
      end
      chk("idle_timeout", 64'(done), 64'd1);
   endtask

   task automatic wait_beats(input int n, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         cyc();
         if (beats_done >= n) done = 1'b1;
      end
      chk("beat_timeout", 64'(done), 64'd1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(dump_valid), 64'd0);
      chk("rst_data", 64'(dump_data), 64'd0);
      chk("rst_idx", 64'(dump_idx), 64'd0);
      chk("rst_last", 64'(dump_last), 64'd0);
      chk("rst_csum", 64'(dump_is_csum), 64'd0);
      chk("rst_rs1", 64'(rs1_addr), 64'd0);
      chk("rst_rs2", 64'(rs2_addr), 64'd0);
   endtask

   task automatic end_of_dump(input string name);
      chk({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_beats"}, 64'(beats_done), 64'(BEATS));
   endtask

   // Sink ready: always 1, or a fair coin per cycle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: read-port order, stall stability, scoreboard pop on each handshake
   initial begin
      beat_t             e;
      bit                hold_v;
      logic [DATA_W-1:0] hold_data;
      logic [ADDR_W-1:0] hold_idx;
      logic              hold_last, hold_csum;
      hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v && dump_valid)
               chk("stall_stable", {dump_data, 25'(dump_idx), dump_last, dump_is_csum},
                   {hold_data, 25'(hold_idx), hold_last, hold_csum});
            hold_v    = dump_valid && !dump_ready;
            hold_data = dump_data;
            hold_idx  = dump_idx;
            hold_last = dump_last;
            hold_csum = dump_is_csum;
            if (!busy) begin
               chk("idle_addr", 64'({rs1_addr, rs2_addr}), 64'd0);
            end else if (rs2_addr != '0) begin
               chk("pair_addr", 64'(rs1_addr), 64'(rs2_addr - ADDR_W'(1)));
               if (int'(rs1_addr) / 2 > seen_pair) seen_pair = int'(rs1_addr) / 2;
            end
            if (dump_valid && dump_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", 64'(dump_idx), 64'hFFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_idx", 64'(dump_idx), 64'(e.idx));
                  chk("beat_data", 64'(dump_data), 64'(e.data));
                  chk("beat_last", 64'(dump_last), 64'(e.last));
                  chk("beat_csum", 64'(dump_is_csum), 64'(e.csum));
                  if (!dump_is_csum)
                     chk("read_before_beat", 64'(int'(dump_idx) / 2 <= seen_pair), 64'd1);
                  beats_done++;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_v, fall;
      rst_n = 1'b0;
      start = 1'b0;
      dump_ready = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h1000_0000 + 32'(i);
      cyc();
      cyc();
      chk_reset_outputs();
      rst_n = 1'b1;
      cyc();

      // Full dump with ready held high: latency and busy fall edge
      start_dump();
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("valid_after_start", 64'(dump_valid), 64'd0);
      first_v = -1;
      fall = -1;
      for (int e = 1; e < 200 && fall < 0; e++) begin
         cyc();
         if (dump_valid && first_v < 0) first_v = e;
         if (!busy) fall = e;
      end
      chk("first_valid_edge", 64'(first_v), 64'd1);
      chk("busy_fall_edge", 64'(fall), 64'(NUM_REGS + 1 + int'(CSUM_EN)));
      end_of_dump("full");

      // Random contents under random backpressure
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
         rand_ready = 1'b1;
         start_dump();
         wait_idle(3000);
         rand_ready = 1'b0;
         cyc();
         end_of_dump("bp");
      end

      // Start pulses while busy, including the final cycle of the dump
      for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
      start_dump();
      wait_beats(5, 200);
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_beats(NUM_REGS - 1, 200);
      chk("busy_at_end_start", 64'(busy), 64'd1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (10) cyc();
      chk("no_restart", 64'(busy), 64'd0);
      end_of_dump("busy_start");

      // Mid-dump reset, then a fresh dump from index 0
      for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
      rand_ready = 1'b1;
      start_dump();
      wait_beats(11, 500);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      rand_ready = 1'b0;
      start_dump();
      wait_idle(200);
      cyc();
      end_of_dump("after_reset");

      // Checksum patterns
      for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'(i) * 32'h0101_0101;
      start_dump();
      wait_idle(200);
      cyc();
      end_of_dump("csum_a");
      rf[5] = 32'hDEAD_BEEF;
      rand_ready = 1'b1;
      start_dump();
      wait_idle(3000);
      rand_ready = 1'b0;
      cyc();
      end_of_dump("csum_b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
